idiv_seq: RTL and testbench

Sequential unsigned integer divider, the inverse companion to the combinational array multipliers (`IMUL1_LOGIC` and `IMUL2_LOGIC`). It computes `Dividend / Divisor` by restoring division, retiring one quotient bit per clock (two with the radix-4 option). Operands are captured on a Start/Busy/Done handshake. Quotient and remainder stay registered until the next operation. It sits beside the multipliers in the datapath and serves divide operations that tolerate multi-cycle latency.

---
 rtl/idiv_seq.sv | 165 ++++++++++++++++
 tb/tb_idiv_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/idiv_seq.sv
// idiv_seq -- sequential unsigned restoring divider.
//
// Computes Dividend / Divisor one quotient bit per clock (two per clock when
// IDIV_RADIX4_EN is defined). Operands are captured on Start while idle.
// Results stay registered until the next operation completes.
//
// Parameters:
//   SIZE       operand/quotient/remainder width (>= 2; even under radix-4)
//
// Configuration macro:
//   IDIV_RADIX4_EN  two chained restoring steps per RUN cycle, latency SIZE/2
//
// Ports:
//   Clock      rising-edge clock
//   Reset      synchronous active-high reset
//   Start      request, sampled only in IDLE
//   Dividend   unsigned dividend, sampled with Start
//   Divisor    unsigned divisor, sampled with Start
//   Quotient   registered quotient (all ones on divide-by-zero)
//   Remainder  registered remainder (Dividend on divide-by-zero)
//   Busy       high while the division is running
//   Done       one-cycle completion pulse
//   DivByZero  set when the last completed operation had a zero divisor

module idiv_seq #(
  parameter int unsigned SIZE = 16
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Start,
  input  logic [SIZE-1:0] Dividend,
  input  logic [SIZE-1:0] Divisor,
  output logic [SIZE-1:0] Quotient,
  output logic [SIZE-1:0] Remainder,
  output logic            Busy,
  output logic            Done,
  output logic            DivByZero
);

`ifdef IDIV_RADIX4_EN
  localparam int unsigned STEPS = SIZE / 2;
`else
  localparam int unsigned STEPS = SIZE;
`endif
  localparam int unsigned CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [SIZE-1:0] r_rem;
  logic [SIZE-1:0] r_q;
  logic [SIZE-1:0] r_div;
  logic [CW-1:0]   r_cnt;

  logic [SIZE-1:0] r_quo_out;
  logic [SIZE-1:0] r_rem_out;
  logic            r_dbz;

  logic [2*SIZE-1:0] w_step1;
  logic [2*SIZE-1:0] w_step;
  logic              w_last;

  // One restoring step on {rem, q}; returns {rem', q'}.
  // The trial is SIZE+1 bits wide so its top bit is the sign of
  // (shifted remainder - divisor).
  function automatic logic [2*SIZE-1:0] f_step(
    input logic [SIZE-1:0] rem,
    input logic [SIZE-1:0] q,
    input logic [SIZE-1:0] d
  );
    logic [SIZE:0] sh;
    logic [SIZE:0] trial;
    sh    = {rem, q[SIZE-1]};
    trial = sh - {1'b0, d};
    if (!trial[SIZE])
      f_step = {trial[SIZE-1:0], q[SIZE-2:0], 1'b1};
    else
      f_step = {sh[SIZE-1:0], q[SIZE-2:0], 1'b0};
  endfunction

  assign w_step1 = f_step(r_rem, r_q, r_div);

`ifdef IDIV_RADIX4_EN
  assign w_step = f_step(w_step1[2*SIZE-1:SIZE], w_step1[SIZE-1:0], r_div);
`else
  assign w_step = w_step1;
`endif

  assign Quotient  = r_quo_out;
  assign Remainder = r_rem_out;
  assign DivByZero = r_dbz;

  always_ff @(posedge Clock) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    Busy   = 1'b0;
    Done   = 1'b0;
    w_last = (r_cnt == LAST);
    case (r_state)
      S_IDLE: begin
        if (Start) w_next = (Divisor == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        Busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        Done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_rem     <= '0;
      r_q       <= '0;
      r_div     <= '0;
      r_cnt     <= '0;
      r_quo_out <= '0;
      r_rem_out <= '0;
      r_dbz     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            if (Divisor != '0) begin
              r_rem <= '0;
              r_q   <= Dividend;
              r_div <= Divisor;
              r_cnt <= '0;
            end else begin
              r_quo_out <= '1;
              r_rem_out <= Dividend;
              r_dbz     <= 1'b1;
            end
          end
        end
        S_RUN: begin
          {r_rem, r_q} <= w_step;
          r_cnt        <= r_cnt + CW'(1);
          if (w_last) begin
            r_quo_out <= w_step[SIZE-1:0];
            r_rem_out <= w_step[2*SIZE-1:SIZE];
            r_dbz     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_idiv_seq.sv
// tb_idiv_seq -- self-checking bench for idiv_seq (SIZE=16).
// Expected results come from plain / and % on the operands; the last
// completed result is kept so holding behaviour can be checked.

module tb_idiv_seq;

`ifdef IDIV_RADIX4_EN
  localparam int N = 8;
`else
  localparam int N = 16;
`endif

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [15:0] Dividend;
  logic [15:0] Divisor;
  logic [15:0] Quotient;
  logic [15:0] Remainder;
  logic        Busy;
  logic        Done;
  logic        DivByZero;

  int n_checks = 0;
  int n_errors = 0;

  // last completed result as predicted by the bench
  logic [15:0] m_q;
  logic [15:0] m_r;
  logic        m_z;

  idiv_seq #(.SIZE(16)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h) t=%0t", tag, got, got, exp, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Run one operation; if inj >= 0, pulse a competing Start after inj busy cycles.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int inj);
    logic [15:0] eq;
    logic [15:0] er;
    logic        ez;
    int          k;
    bit          seen;
    if (b == 16'd0) begin
      eq = 16'hFFFF; er = a; ez = 1'b1;
    end else begin
      eq = a / b; er = a % b; ez = 1'b0;
    end
    @(negedge Clock);
    Dividend = a;
    Divisor  = b;
    Start    = 1'b1;
    tick();
    Start = 1'b0;
    k = 0;
    seen = 0;
    while (!seen && k <= N + 4) begin
      if (Done) begin
        seen = 1;
      end else begin
        check("busy_run", Busy, 1);
        check("hold_q", Quotient, m_q);
        check("hold_r", Remainder, m_r);
        check("hold_z", DivByZero, m_z);
        if (inj >= 0 && k == inj) begin
          @(negedge Clock);
          Start    = 1'b1;
          Dividend = 16'd50;
          Divisor  = 16'd5;
        end
        tick();
        Start = 1'b0;
        k++;
      end
    end
    check("done_seen", seen, 1);
    check("latency", k, (b == 16'd0) ? 0 : N);
    check("busy_at_done", Busy, 0);
    check("quotient", Quotient, eq);
    check("remainder", Remainder, er);
    check("divbyzero", DivByZero, ez);
    m_q = eq; m_r = er; m_z = ez;
    tick();
    check("done_pulse", Done, 0);
    check("idle_busy", Busy, 0);
    check("idle_hold_q", Quotient, m_q);
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b1;          // ignored while in reset
    Dividend = 16'd9;
    Divisor  = 16'd3;
    m_q = '0; m_r = '0; m_z = 1'b0;
    repeat (3) tick();
    check("rst_q", Quotient, 0);
    check("rst_r", Remainder, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_z", DivByZero, 0);
    @(negedge Clock);
    Reset = 1'b0;
    Start = 1'b0;
    tick();
    check("post_rst_busy", Busy, 0);

    do_op(16'd1000, 16'd7, -1);
    do_op(16'hFFFF, 16'd1, -1);
    do_op(16'd3, 16'd10, -1);
    do_op(16'd5, 16'd0, -1);
    do_op(16'd9, 16'd3, -1);
    do_op(16'd100, 16'd9, 4);
    do_op(16'hFFFF, 16'h00FF, -1);
    do_op(16'd0, 16'd0, -1);
    do_op(16'h8000, 16'hFFFF, -1);
    do_op(16'hFFFF, 16'hFFFF, -1);

    // Reset in the middle of a run, with Start also high
    @(negedge Clock);
    Dividend = 16'd1000;
    Divisor  = 16'd7;
    Start    = 1'b1;
    tick();
    Start = 1'b0;
    repeat (7) tick();
    @(negedge Clock);
    Reset = 1'b1;
    Start = 1'b1;
    tick();
    check("midrst_q", Quotient, 0);
    check("midrst_r", Remainder, 0);
    check("midrst_busy", Busy, 0);
    check("midrst_done", Done, 0);
    check("midrst_z", DivByZero, 0);
    @(negedge Clock);
    Reset = 1'b0;
    Start = 1'b0;
    m_q = '0; m_r = '0; m_z = 1'b0;
    begin
      int pulses = 0;
      for (int i = 0; i < N + 4; i++) begin
        tick();
        if (Done || Busy) pulses++;
      end
      check("midrst_no_done", pulses, 0);
    end
    do_op(16'd20, 16'd6, -1);

    // randomized operations
    for (int i = 0; i < 40; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'($urandom_range(0, 4));
        1:       b = 16'($urandom_range(0, 255));
        default: b = 16'($urandom);
      endcase
      do_op(a, b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
